id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register for the RISC-V core.
- Consumes the register file read ports (rs1_data/rs2_data), which already bypass same-cycle writeback.
- Resolves EX and MEM forwarding, detects load-use hazards, inserts bubbles, and honours downstream stall and flush.
- Counts load-use bubbles for performance analysis.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  XLEN  ID PC.
- id_imm  in  XLEN  decoded immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2.
- id_regwrite, id_memread, id_memwrite  in  1  control bits.
- id_alu_op  in  4  ALU operation.
- rs1_data, rs2_data  in  XLEN  register file read data.
- ex_result  in  XLEN  combinational ALU result of the instruction currently in ex_*.
- mem_valid, mem_regwrite  in  1  MEM-stage instruction status.
- mem_rd  in  5  MEM-stage destination.
- mem_result  in  XLEN  final MEM-stage value (load data already selected).
- ex_stall  in  1  freeze of EX and later stages.
- flush  in  1  kill the ID instruction (branch/jump redirect).
- ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1  registered control.
- ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  XLEN  registered data.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_alu_op  out  4  registered ALU operation.
- id_stall  out  1  hold PC and IF/ID.
- lu_bubble_cnt  out  CNT_W  load-use bubble count.

Behaviour:
- Reset (rst_n=0 at posedge): every ex_* output is 0 and lu_bubble_cnt is 0. id_stall is combinational and reads 0 while the stage is empty.
- Latency: 1 cycle from ID to ex_*.
- load_use (combinational) = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- id_stall = (load_use | ex_stall) & ~flush.
- Operand select, applied to rs1 and rs2 independently; first match wins:
  1. Index 0: value 0.
  2. ex_valid & ex_regwrite & ~ex_memread & ex_rd==idx: ex_result.
  3. mem_valid & mem_regwrite & mem_rd==idx: mem_result.
  4. Otherwise: rs*_data.
- Per-posedge update of ex_*, highest priority first:
  1. Reset.
  2. flush: bubble. Flush overrides ex_stall.
  3. ex_stall: hold all ex_* unchanged.
  4. load_use: bubble, and increment lu_bubble_cnt.
  5. Otherwise: capture ID fields and the selected operands. ex_valid = id_valid; regwrite/memread/memwrite are ANDed with id_valid.
- Bubble: all ex_* fields, including data, cleared to 0.
- lu_bubble_cnt: saturates at all-ones. It increments only in the load_use bubble case (no flush, no ex_stall).
- Stall semantics:
  - During ex_stall, ID operands are re-evaluated every cycle and captured only on the release edge.
  - The forwarding sources are frozen by the same ex_stall.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle the load sits in MEM and the value comes from mem_result.
- x0 never forwards and never triggers load_use, even if ex_rd/mem_rd = 0 with regwrite set.

Test Plan:
- Reset with rst_n=0 for 2 cycles while id_valid=1 → all ex_*=0, lu_bubble_cnt=0; the first capture occurs on the first edge after release.
- EX forwarding: ADD x5 (ex_result=0x11) in EX; ID reads rs1=x5, rs2=x5; rs1_data=0xDEAD → ex_rs1_val=ex_rs2_val=0x11.
- EX/MEM priority: ex_rd=mem_rd=7 with ex_result=0xAA, mem_result=0xBB, ID rs2=x7 → ex_rs2_val=0xAA. Same with ex_regwrite=0 → 0xBB. With rs2=x0 → 0.
- Load-use: LW x3 in EX, ID uses x3 → id_stall=1 for 1 cycle, bubble (ex_valid=0), lu_bubble_cnt 0→1. Next cycle mem_result=0x1234 is captured into ex_rs1_val.
- Stall vs flush: ex_stall=1 for 3 cycles → ex_* held and id_stall=1. Then flush together with ex_stall → next edge ex_valid=0 and the counter is unchanged.
- Counter saturation: preload via 65535 load-use events, then one more → lu_bubble_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard
// handling.
//
// Control semantics: ex_valid marks a live instruction in the EX register.
// ex_stall freezes EX and everything behind it, so the forwarding sources
// (ex_*, mem_*) stay put while it is high. id_stall tells IF/ID to hold
// its instruction. flush kills the ID instruction and wins over every
// stall. A stalled ID instruction is captured only on the edge where the
// stall drops, with its operands re-selected on that cycle.
module id_ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic [3:0]       id_alu_op,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             id_stall,
  output logic [CNT_W-1:0] lu_bubble_cnt
);

  logic            load_use;
  logic            do_bubble;
  logic            ex_fwd_ok;
  logic            mem_fwd_ok;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;

  // A load in EX cannot forward yet; a dependent ID instruction must wait.
  always_comb begin
    load_use = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) |
                (id_use_rs2 & (id_rs2 == ex_rd)));
    id_stall  = (load_use | ex_stall) & ~flush;
    do_bubble = flush | (~ex_stall & load_use);
  end

  // Operand select per source: x0, then EX (non-load), then MEM, then regfile.
  always_comb begin
    ex_fwd_ok  = ex_valid & ex_regwrite & ~ex_memread;
    mem_fwd_ok = mem_valid & mem_regwrite;

    rs1_sel = rs1_data;
    if (id_rs1 == 5'd0)                      rs1_sel = '0;
    else if (ex_fwd_ok && ex_rd == id_rs1)   rs1_sel = ex_result;
    else if (mem_fwd_ok && mem_rd == id_rs1) rs1_sel = mem_result;

    rs2_sel = rs2_data;
    if (id_rs2 == 5'd0)                      rs2_sel = '0;
    else if (ex_fwd_ok && ex_rd == id_rs2)   rs2_sel = ex_result;
    else if (mem_fwd_ok && mem_rd == id_rs2) rs2_sel = mem_result;
  end

  // EX register: reset/bubble clears everything, stall holds, else capture.
  always_ff @(posedge clk) begin
    if (!rst_n || do_bubble) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_alu_op   <= 4'd0;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite & id_valid;
      ex_memread  <= id_memread & id_valid;
      ex_memwrite <= id_memwrite & id_valid;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rs1_val  <= rs1_sel;
      ex_rs2_val  <= rs2_sel;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_alu_op   <= id_alu_op;
    end
  end

  // Saturating count of bubbles caused purely by load-use hazards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_bubble_cnt <= '0;
    end else if (!flush && !ex_stall && load_use &&
                 lu_bubble_cnt != {CNT_W{1'b1}}) begin
      lu_bubble_cnt <= lu_bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios followed by random
// traffic, checked against a behavioural model through an expected queue.
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            id_valid, id_use_rs1, id_use_rs2;
  logic            id_regwrite, id_memread, id_memwrite;
  logic [XLEN-1:0] id_pc, id_imm, rs1_data, rs2_data, ex_result, mem_result;
  logic [4:0]      id_rs1, id_rs2, id_rd, mem_rd;
  logic [3:0]      id_alu_op;
  logic            mem_valid, mem_regwrite, ex_stall, flush;
  logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_alu_op;
  logic            id_stall;
  logic [CW-1:0]   lu_bubble_cnt;

  id_ex_operand_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_alu_op(id_alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_result(mem_result), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .id_stall(id_stall), .lu_bubble_cnt(lu_bubble_cnt)
  );

  // ---------------- model state and scoreboard ----------------
  typedef struct packed {
    logic v, rw, mr, mw;
    logic [XLEN-1:0] pc, imm, a, b;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] op;
    logic [CW-1:0] cnt;
  } snap_t;
  localparam int SW = $bits(snap_t);

  snap_t     m;              // what the EX register should hold right now
  logic [SW-1:0] exp_q[$];   // expected EX contents after each edge
  logic      stall_q[$];     // expected id_stall for the current cycle
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view of operand resolution: the newest producer wins,
  // x0 is hardwired zero, and a load still in EX has no value to give.
  function automatic logic [XLEN-1:0] pick(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
    if (m.v && m.rw && !m.mr && m.rd == idx) return ex_result;
    if (mem_valid && mem_regwrite && mem_rd == idx) return mem_result;
    return rf;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_pc = '0; id_imm = '0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_alu_op = 0; rs1_data = '0; rs2_data = '0; ex_result = '0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_result = '0;
    ex_stall = 0; flush = 0;
  endtask

  // Inputs are already applied; predict this cycle and the next EX contents,
  // then advance one clock.
  task automatic step();
    snap_t n;
    logic  lu;
    lu = id_valid && m.v && m.mr && (m.rd != 0) &&
         ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
    stall_q.push_back((lu || ex_stall) && !flush);
    n = m;
    if (!rst_n) begin
      n = '0;
    end else if (flush) begin
      n = '0; n.cnt = m.cnt;
    end else if (ex_stall) begin
      n = m;
    end else if (lu) begin
      n = '0;
      n.cnt = (m.cnt == {CW{1'b1}}) ? m.cnt : m.cnt + 1'b1;
    end else begin
      n.v = id_valid; n.rw = id_regwrite && id_valid;
      n.mr = id_memread && id_valid; n.mw = id_memwrite && id_valid;
      n.pc = id_pc; n.imm = id_imm;
      n.a = pick(id_rs1, rs1_data); n.b = pick(id_rs2, rs2_data);
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.op = id_alu_op;
    end
    m = n;
    exp_q.push_back(n);
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2);
    id_valid = 1; id_rd = rd; id_regwrite = rw; id_memread = mr; id_memwrite = 0;
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_pc = id_pc + 4; id_imm = $urandom; id_alu_op = 4'($urandom);
    rs1_data = $urandom; rs2_data = $urandom;
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      snap_t e;
      e = snap_t'(exp_q.pop_front());
      check("ex_valid", 32'(ex_valid), 32'(e.v));
      check("ex_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, {29'd0, e.rw, e.mr, e.mw});
      check("ex_pc", ex_pc, e.pc);
      check("ex_imm", ex_imm, e.imm);
      check("ex_rs1_val", ex_rs1_val, e.a);
      check("ex_rs2_val", ex_rs2_val, e.b);
      check("ex_idx", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
      check("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
      check("lu_bubble_cnt", 32'(lu_bubble_cnt), 32'(e.cnt));
    end
  end

  always @(negedge clk) begin
    if (stall_q.size() > 0) check("id_stall", 32'(id_stall), 32'(stall_q.pop_front()));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    m = '0;
    idle();
    rst_n = 0;
    @(posedge clk); #2;
    // reset held with a valid instruction in ID
    issue(5'd9, 1, 0, 5'd1, 1, 5'd2, 1);
    step(); step();
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_cnt", 32'(lu_bubble_cnt), 32'd0);
    rst_n = 1;
    step();
    check("first_capture", 32'(ex_valid), 32'd1);

    // EX forwarding: ADD x5 in EX, ID reads x5 twice
    issue(5'd5, 1, 0, 5'd1, 1, 5'd2, 1); step();
    issue(5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
    rs1_data = 32'hDEAD; ex_result = 32'h11; step();
    check("fwd_ex_rs1", ex_rs1_val, 32'h11);
    check("fwd_ex_rs2", ex_rs2_val, 32'h11);

    // EX beats MEM; MEM used when EX does not write; x0 reads zero
    mem_valid = 1; mem_regwrite = 1; mem_rd = 7; mem_result = 32'hBB;
    issue(5'd7, 1, 0, 5'd0, 0, 5'd0, 0); step();
    issue(5'd8, 1, 0, 5'd1, 1, 5'd7, 1); ex_result = 32'hAA; step();
    check("prio_ex", ex_rs2_val, 32'hAA);
    issue(5'd7, 0, 0, 5'd0, 0, 5'd0, 0); step();
    issue(5'd8, 1, 0, 5'd1, 1, 5'd7, 1); step();
    check("prio_mem", ex_rs2_val, 32'hBB);
    issue(5'd8, 1, 0, 5'd1, 1, 5'd0, 1); step();
    check("x0_zero", ex_rs2_val, 32'h0);
    mem_valid = 0;

    // load-use: LW x3 then a dependent instruction
    issue(5'd3, 1, 1, 5'd0, 0, 5'd0, 0); step();
    issue(5'd4, 1, 0, 5'd3, 1, 5'd0, 0); step();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_cnt", 32'(lu_bubble_cnt), 32'd1);
    mem_valid = 1; mem_regwrite = 1; mem_rd = 3; mem_result = 32'h1234; step();
    check("lu_mem_fwd", ex_rs1_val, 32'h1234);
    mem_valid = 0;

    // stall for three cycles, then flush together with stall
    issue(5'd10, 1, 0, 5'd1, 1, 5'd2, 1); step();
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd11, 1, 0, 5'd3, 1, 5'd4, 1); step();
    end
    check("stall_hold_rd", 32'(ex_rd), 32'd10);
    flush = 1; step();
    check("flush_over_stall", 32'(ex_valid), 32'd0);
    check("flush_cnt", 32'(lu_bubble_cnt), 32'd1);
    flush = 0; ex_stall = 0;

    // drive the counter past saturation
    for (int i = 0; i < 20; i++) begin
      issue(5'd3, 1, 1, 5'd0, 0, 5'd0, 0); step();
      issue(5'd4, 1, 0, 5'd0, 0, 5'd3, 1); step();
    end
    check("cnt_saturate", 32'(lu_bubble_cnt), 32'(4'hF));

    // random traffic with small register indices to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = ($urandom_range(0, 1) == 1); id_use_rs2 = ($urandom_range(0, 1) == 1);
      id_regwrite = ($urandom_range(0, 1) == 1); id_memread = ($urandom_range(0, 2) == 0);
      id_memwrite = ($urandom_range(0, 3) == 0); id_alu_op = 4'($urandom);
      rs1_data = $urandom; rs2_data = $urandom; ex_result = $urandom;
      mem_valid = ($urandom_range(0, 1) == 1); mem_regwrite = ($urandom_range(0, 1) == 1);
      mem_rd = 5'($urandom_range(0, 3)); mem_result = $urandom;
      ex_stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      step();
    end

    idle(); step();
    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
